char_spawn_scheduler: RTL and testbench

- Schedules new falling characters for the typing-game screen: periodically picks a free display lane round-robin, draws a character code 1..70 from an internal 8-bit LFSR, rejects codes already on screen, and offers the (lane, char) pair to the renderer over a valid/ready handshake.
- Tracks lane occupancy; lanes are released when the game logic reports a character typed or expired.

---
 rtl/char_spawn_scheduler_pkg.sv | 29 ++
 rtl/char_spawn_scheduler_if.sv | 28 ++
 rtl/char_spawn_scheduler_lfsr8_step.sv | 33 +++
 rtl/char_spawn_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_char_spawn_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_spawn_scheduler_pkg.sv
// Shared constants, FSM state type and the LFSR step function for the
// character spawn scheduler.
package char_spawn_scheduler_pkg;

   localparam logic [7:0] LFSR_SEED          = 8'd111;
   localparam logic [7:0] LFSR_LOCKUP_SEED   = 8'd12;
   localparam int         CHAR_RANGE_DEFAULT = 70;
   localparam int         CHAR_W             = 8;

   typedef enum logic [1:0] {
      IDLE,
      PICK,
      DRAW,
      OFFER
   } state_t;

   // One step of the 1+x^2+x^3+x^4+x^8 shift register. An all-zero register
   // would never leave zero, so it is reloaded with a fixed non-zero value.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      logic [7:0] n;
      if (q == 8'd0) begin
         n = LFSR_LOCKUP_SEED;
      end else begin
         n = {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
      end
      return n;
   endfunction

endpackage

// File: rtl/char_spawn_scheduler_if.sv
// Spawn offer handshake between the scheduler (master) and the renderer (slave).
interface char_spawn_scheduler_if #(
   parameter int LANES = 8
);
   import char_spawn_scheduler_pkg::*;

   localparam int LANE_W = $clog2(LANES);

   logic              spawn_valid;
   logic              spawn_ready;
   logic [LANE_W-1:0] spawn_lane;
   logic [CHAR_W-1:0] spawn_char;

   modport master (
      output spawn_valid,
      output spawn_lane,
      output spawn_char,
      input  spawn_ready
   );

   modport slave (
      input  spawn_valid,
      input  spawn_lane,
      input  spawn_char,
      output spawn_ready
   );

endinterface

// File: rtl/char_spawn_scheduler_lfsr8_step.sv
// 8-bit LFSR that only moves when asked to, used as the character source.
module lfsr8_step
   import char_spawn_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   output logic [7:0] q
);

   logic [7:0] q_d;
   logic [7:0] q_q;

   // Hold the value unless the scheduler consumes a draw this cycle.
   always_comb begin
      q_d = q_q;
      if (advance) begin
         q_d = lfsr_next(q_q);
      end
   end

   // State register, reloaded with the seed on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/char_spawn_scheduler.sv
// Periodically picks a free display lane round-robin, draws a character that
// is not already on screen (within a retry budget) and offers the pair to the
// renderer. Lane occupancy is tracked until the game logic releases the lane.
module char_spawn_scheduler
   import char_spawn_scheduler_pkg::*;
#(
   parameter int LANES        = 8,
   parameter int SPAWN_PERIOD = 25000000,
   parameter int CHAR_RANGE   = CHAR_RANGE_DEFAULT,
   parameter int MAX_RETRY    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [LANES-1:0]       lane_free,
   char_spawn_scheduler_if.master spawn,
   output logic [LANES-1:0]       lane_busy,
   output logic [$clog2(LANES):0] active_count
);

   localparam int LANE_W  = $clog2(LANES);
   localparam int CNT_W   = LANE_W + 1;
   localparam int TIMER_W = $clog2(SPAWN_PERIOD);
   localparam int RETRY_W = $clog2(MAX_RETRY + 2);

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                pending_q, pending_d;
   logic                spawn_valid_q, spawn_valid_d;
   logic [LANE_W-1:0]   spawn_lane_q, spawn_lane_d;
   logic [CHAR_W-1:0]   spawn_char_q, spawn_char_d;
   logic [LANE_W-1:0]   rr_last_q, rr_last_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [LANES-1:0]    lane_busy_q, lane_busy_d;
   logic [CHAR_W-1:0]   lane_char_q [LANES];
   logic [CHAR_W-1:0]   lane_char_d [LANES];
   logic [CNT_W-1:0]    active_count_q, active_count_d;

   logic                tick;
   logic                handshake;
   logic                lfsr_advance;
   logic [7:0]          lfsr_q;
   logic [CHAR_W-1:0]   draw_code;
   logic                dup_hit;
   logic                pick_found;
   logic [LANE_W-1:0]   pick_lane;
   logic [LANE_W-1:0]   pick_cand;

   lfsr8_step u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (lfsr_advance),
      .q       (lfsr_q)
   );

   assign draw_code = CHAR_W'((int'(lfsr_q) % CHAR_RANGE) + 1);

   // Spawn timer: runs only while enabled and produces one tick per period.
   always_comb begin
      timer_d = timer_q;
      tick    = 1'b0;
      if (enable) begin
         if (timer_q == TIMER_W'(SPAWN_PERIOD - 1)) begin
            timer_d = '0;
            tick    = 1'b1;
         end else begin
            timer_d = timer_q + TIMER_W'(1);
         end
      end
   end

   // Round-robin search for the first idle lane after the last one spawned into.
   always_comb begin
      pick_found = 1'b0;
      pick_lane  = '0;
      pick_cand  = '0;
      for (int k = 1; k <= LANES; k++) begin
         pick_cand = rr_last_q + LANE_W'(k);
         if (!pick_found && !lane_busy_q[pick_cand]) begin
            pick_found = 1'b1;
            pick_lane  = pick_cand;
         end
      end
   end

   // A draw is a duplicate if any occupied lane already shows that code.
   always_comb begin
      dup_hit = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         if (lane_busy_q[l] && (lane_char_q[l] == draw_code)) begin
            dup_hit = 1'b1;
         end
      end
   end

   // Spawn sequencer: pick a lane, draw a character, then hold the offer.
   always_comb begin
      state_d       = state_q;
      spawn_valid_d = spawn_valid_q;
      spawn_lane_d  = spawn_lane_q;
      spawn_char_d  = spawn_char_q;
      rr_last_d     = rr_last_q;
      retry_d       = retry_q;
      lfsr_advance  = 1'b0;
      handshake     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d = PICK;
            end
         end
         PICK: begin
            if (pick_found) begin
               spawn_lane_d = pick_lane;
               retry_d      = '0;
               state_d      = DRAW;
            end else begin
               state_d = IDLE;
            end
         end
         DRAW: begin
            lfsr_advance = 1'b1;
            if (dup_hit && (int'(retry_q) < MAX_RETRY)) begin
               retry_d = retry_q + RETRY_W'(1);
            end else begin
               spawn_char_d  = draw_code;
               spawn_valid_d = 1'b1;
               state_d       = OFFER;
            end
         end
         OFFER: begin
            if (spawn.spawn_ready) begin
               handshake     = 1'b1;
               spawn_valid_d = 1'b0;
               rr_last_d     = spawn_lane_q;
               state_d       = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A spawn request stays pending until accepted; ticks arriving meanwhile are dropped.
   always_comb begin
      pending_d = pending_q;
      if (handshake) begin
         pending_d = 1'b0;
      end else if (tick) begin
         pending_d = 1'b1;
      end
   end

   // Lane occupancy: releases and a new spawn on another lane apply together.
   always_comb begin
      lane_busy_d = lane_busy_q & ~lane_free;
      lane_char_d = lane_char_q;
      if (handshake) begin
         lane_busy_d[spawn_lane_q] = 1'b1;
         lane_char_d[spawn_lane_q] = spawn_char_q;
      end
      active_count_d = '0;
      for (int l = 0; l < LANES; l++) begin
         active_count_d = active_count_d + CNT_W'(lane_busy_d[l]);
      end
   end

   // All scheduler state, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         pending_q      <= 1'b0;
         spawn_valid_q  <= 1'b0;
         spawn_lane_q   <= '0;
         spawn_char_q   <= '0;
         rr_last_q      <= LANE_W'(LANES - 1);
         retry_q        <= '0;
         lane_busy_q    <= '0;
         active_count_q <= '0;
         for (int l = 0; l < LANES; l++) begin
            lane_char_q[l] <= '0;
         end
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         pending_q      <= pending_d;
         spawn_valid_q  <= spawn_valid_d;
         spawn_lane_q   <= spawn_lane_d;
         spawn_char_q   <= spawn_char_d;
         rr_last_q      <= rr_last_d;
         retry_q        <= retry_d;
         lane_busy_q    <= lane_busy_d;
         active_count_q <= active_count_d;
         lane_char_q    <= lane_char_d;
      end
   end

   assign spawn.spawn_valid = spawn_valid_q;
   assign spawn.spawn_lane  = spawn_lane_q;
   assign spawn.spawn_char  = spawn_char_q;
   assign lane_busy         = lane_busy_q;
   assign active_count      = active_count_q;

endmodule

// File: tb/tb_char_spawn_scheduler.sv
// Testbench for char_spawn_scheduler: directed latency/stall/reset steps and
// randomized lane releases checked against a transaction-level model.
module tb_char_spawn_scheduler;

   localparam int LANES  = 8;
   localparam int PERIOD = 8;
   localparam int RANGE  = 70;

   logic       clk;
   logic       rst;
   logic       enA, enB;
   logic [7:0] freeA, freeB;
   logic [7:0] busyA, busyB;
   logic [3:0] actA, actB;

   char_spawn_scheduler_if #(.LANES(LANES)) ifA ();
   char_spawn_scheduler_if #(.LANES(LANES)) ifB ();

   char_spawn_scheduler #(
      .LANES(LANES), .SPAWN_PERIOD(PERIOD), .CHAR_RANGE(RANGE), .MAX_RETRY(4)
   ) dutA (
      .clk(clk), .rst(rst), .enable(enA), .lane_free(freeA),
      .spawn(ifA), .lane_busy(busyA), .active_count(actA)
   );

   char_spawn_scheduler #(
      .LANES(LANES), .SPAWN_PERIOD(PERIOD), .CHAR_RANGE(RANGE), .MAX_RETRY(0)
   ) dutB (
      .clk(clk), .rst(rst), .enable(enB), .lane_free(freeB),
      .spawn(ifB), .lane_busy(busyB), .active_count(actB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared;
   int mismatched;
   int sel;

   // Transaction-level model of the scheduler's visible state
   bit [7:0] mBusy;
   int       mChar [LANES];
   int       mRr;
   int       mLfsr;
   int       mMaxRetry;
   int       dupRejects;
   int       dupAccepts;

   function automatic logic [31:0] obsValid();
      return (sel == 0) ? 32'(ifA.spawn_valid) : 32'(ifB.spawn_valid);
   endfunction

   function automatic logic [31:0] obsLane();
      return (sel == 0) ? 32'(ifA.spawn_lane) : 32'(ifB.spawn_lane);
   endfunction

   function automatic logic [31:0] obsChar();
      return (sel == 0) ? 32'(ifA.spawn_char) : 32'(ifB.spawn_char);
   endfunction

   function automatic logic [31:0] obsBusy();
      return (sel == 0) ? 32'(busyA) : 32'(busyB);
   endfunction

   function automatic logic [31:0] obsActive();
      return (sel == 0) ? 32'(actA) : 32'(actB);
   endfunction

   // Galois form of the spawn LFSR polynomial (0x11D)
   function automatic int lfsrNext(input int q);
      if (q == 0) return 12;
      return ((q << 1) & 255) ^ (((q & 128) != 0) ? 29 : 0);
   endfunction

   task automatic modelReset(input int maxRetry);
      mBusy     = '0;
      mRr       = LANES - 1;
      mLfsr     = 111;
      mMaxRetry = maxRetry;
      for (int l = 0; l < LANES; l++) mChar[l] = 0;
   endtask

   task automatic predictOffer(output int lane, output int ch);
      int  retry;
      int  code;
      bit  dup;
      bit  done;
      lane = -1;
      for (int k = 1; k <= LANES; k++) begin
         if (lane < 0 && !mBusy[(mRr + k) % LANES]) lane = (mRr + k) % LANES;
      end
      retry = 0;
      done  = 1'b0;
      ch    = 0;
      while (!done) begin
         code  = mLfsr % RANGE + 1;
         mLfsr = lfsrNext(mLfsr);
         dup   = 1'b0;
         for (int l = 0; l < LANES; l++) begin
            if (mBusy[l] && mChar[l] == code) dup = 1'b1;
         end
         if (dup && retry < mMaxRetry) begin
            retry++;
            dupRejects++;
         end else begin
            if (dup) dupAccepts++;
            ch   = code;
            done = 1'b1;
         end
      end
   endtask

   task automatic modelAccept(input int lane, input int ch, input bit [7:0] fr);
      mBusy       = (mBusy & ~fr) | (8'd1 << lane);
      mChar[lane] = ch;
      mRr         = lane;
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic [7:0] fr);
      if (sel == 0) begin
         enA = en; ifA.spawn_ready = rdy; freeA = fr;
      end else begin
         enB = en; ifB.spawn_ready = rdy; freeB = fr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "Valid"}, obsValid(), 0);
      checkOutput({tag, "Lane"}, obsLane(), 0);
      checkOutput({tag, "Char"}, obsChar(), 0);
      checkOutput({tag, "Busy"}, obsBusy(), 0);
      checkOutput({tag, "Active"}, obsActive(), 0);
   endtask

   task automatic waitOffer(input int budget, output bit ok);
      ok = (obsValid() === 32'd1);
      for (int i = 0; i < budget && !ok; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00);
         ok = (obsValid() === 32'd1);
      end
      checkOutput("offerWait", 32'(ok), 1);
   endtask

   // Runs from just after reset release with ready held high; offers appear
   // three edges after each timer wrap (wraps on edges 8, 16, 24).
   task automatic latencyRun(input int lastEdge);
      int expLane [3];
      int expChar [3];
      int n;
      int l, c;
      expLane = '{0, 1, 2};
      expChar = '{42, 13, 22};
      n = 0;
      for (int e = 1; e <= lastEdge; e++) begin
         applyStimulus(1'b1, 1'b1, 8'h00);
         checkOutput("latBusy", obsBusy(), 32'(mBusy));
         if (e >= 11 && (e % 8) == 3) begin
            checkOutput("latValidHigh", obsValid(), 1);
            predictOffer(l, c);
            checkOutput("latLane", obsLane(), 32'(expLane[n]));
            checkOutput("latChar", obsChar(), 32'(expChar[n]));
            modelAccept(l, c, 8'h00);
            n++;
         end else begin
            checkOutput("latValidLow", obsValid(), 0);
         end
      end
      applyStimulus(1'b1, 1'b1, 8'h00);
      checkOutput("latBusyEnd", obsBusy(), 32'(mBusy));
      checkOutput("latActiveEnd", obsActive(), 32'($countones(mBusy)));
      checkOutput("latValidEnd", obsValid(), 0);
   endtask

   task automatic doTransaction();
      bit       ok;
      int       l, c, r, stall;
      bit [7:0] fr;
      if (mBusy == 8'hFF) begin
         for (int i = 0; i < 3 * PERIOD; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput("fullNoValid", obsValid(), 0);
         end
         r = $urandom_range(0, LANES - 1);
         applyStimulus(1'b1, 1'b0, 8'd1 << r);
         mBusy[r] = 1'b0;
         checkOutput("fullFreeBusy", obsBusy(), 32'(mBusy));
         waitOffer(4 + mMaxRetry, ok);
         if (ok) checkOutput("fullFreedLane", obsLane(), 32'(r));
      end else begin
         waitOffer(100, ok);
      end
      if (!ok) return;
      predictOffer(l, c);
      checkOutput("rndLane", obsLane(), 32'(l));
      checkOutput("rndChar", obsChar(), 32'(c));
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
         fr = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom) & mBusy) : 8'h00;
         applyStimulus(1'b1, 1'b0, fr);
         mBusy = mBusy & ~fr;
         checkOutput("stallValid", obsValid(), 1);
         checkOutput("stallLane", obsLane(), 32'(l));
         checkOutput("stallChar", obsChar(), 32'(c));
         checkOutput("stallBusy", obsBusy(), 32'(mBusy));
      end
      fr = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'h00;
      applyStimulus(1'b1, 1'b1, fr);
      modelAccept(l, c, fr);
      checkOutput("hsValidDrop", obsValid(), 0);
      checkOutput("hsBusy", obsBusy(), 32'(mBusy));
      checkOutput("hsActive", obsActive(), 32'($countones(mBusy)));
   endtask

   initial begin
      bit ok;
      int l, c;
      int prevActive;
      compared   = 0;
      mismatched = 0;
      dupRejects = 0;
      dupAccepts = 0;
      sel        = 1;
      enB = 1'b0; ifB.spawn_ready = 1'b0; freeB = 8'h00;
      sel        = 0;
      enA = 1'b0; ifA.spawn_ready = 1'b0; freeA = 8'h00;
      rst = 1'b1;
      modelReset(4);

      // Reset values, then the first three offers with exact latency
      repeat (3) applyStimulus(1'b1, 1'b1, 8'h00);
      checkResetState("reset");
      rst = 1'b0;
      latencyRun(27);
      checkOutput("busyAfterThree", obsBusy(), 32'h07);

      // Renderer stalls for five cycles; offer must hold steady
      waitOffer(100, ok);
      predictOffer(l, c);
      checkOutput("stallOfferLane", obsLane(), 3);
      prevActive = $countones(mBusy);
      for (int s = 0; s < 5; s++) begin
         applyStimulus(1'b1, 1'b0, 8'h00);
         checkOutput("hold5Valid", obsValid(), 1);
         checkOutput("hold5Lane", obsLane(), 32'(l));
         checkOutput("hold5Char", obsChar(), 32'(c));
      end
      applyStimulus(1'b1, 1'b1, 8'h00);
      modelAccept(l, c, 8'h00);
      checkOutput("hold5Busy", obsBusy(), 32'h0F);
      checkOutput("hold5Active", obsActive(), 32'(prevActive + 1));

      // Release lanes 1 and 3 in the same cycle as accepting lane 4
      waitOffer(100, ok);
      predictOffer(l, c);
      checkOutput("mixLane", obsLane(), 4);
      checkOutput("mixChar", obsChar(), 32'(c));
      applyStimulus(1'b1, 1'b1, 8'b0000_1010);
      modelAccept(l, c, 8'b0000_1010);
      checkOutput("mixBusy", obsBusy(), 32'h15);
      checkOutput("mixActive", obsActive(), 3);

      // Reset while an offer is outstanding withdraws it
      waitOffer(100, ok);
      predictOffer(l, c);
      checkOutput("preRstLane", obsLane(), 5);
      checkOutput("preRstValid", obsValid(), 1);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00);
      rst = 1'b0;
      checkResetState("midRst");
      modelReset(4);
      latencyRun(11);

      // Randomized release traffic with retry budget 4
      for (int t = 0; t < 150; t++) doTransaction();
      $display("[TB] retry=4 phase: duplicate draws rejected=%0d accepted=%0d", dupRejects, dupAccepts);

      // Same traffic against the instance that never retries
      applyStimulus(1'b0, 1'b0, 8'h00);
      sel        = 1;
      dupRejects = 0;
      dupAccepts = 0;
      modelReset(0);
      checkResetState("bReset");
      for (int t = 0; t < 100; t++) doTransaction();
      $display("[TB] retry=0 phase: duplicate draws rejected=%0d accepted=%0d", dupRejects, dupAccepts);
      checkOutput("bNoRejects", 32'(dupRejects), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
